// File: rtl/channel_loader.sv
// channel_loader: saturates the incoming LLR stream and packs it into
// P-wide storage words, then hands storage to the decoder for the frame.
module channel_loader #(
  parameter int N  = 1024,
  parameter int P  = 128,
  parameter int Q  = 6,
  parameter int K  = 8,
  parameter int QI = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [K*QI-1:0] llr_in,
  input  logic            llr_valid,
  output logic            llr_ready,
  input  logic            decode_done,
  input  logic            frame_abort,
  output logic [P*Q-1:0]  W_channel,
  output logic [5:0]      channel_count,
  output logic            channel_ready,
  output logic            channel
);

  localparam int BEATS = P / K;
  localparam int WORDS = N / P;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BW-1:0] BLAST = BW'(BEATS - 1);
  localparam logic [5:0]    WLAST = 6'(WORDS - 1);

  localparam logic signed [QI-1:0] SMAX =
    QI'(2 ** (Q - 1) - 1);
  localparam logic signed [QI-1:0] SMIN =
    QI'(-(2 ** (Q - 1) - 1));

  typedef enum logic [1:0] {
    LOAD,
    EMIT,
    DECODE
  } state_t;

  state_t          state;
  logic [BW-1:0]   bcnt;
  logic [5:0]      wcnt;
  logic [P*Q-1:0]  wbuf;
  logic [P*Q-1:0]  wbuf_nxt;

  // Symmetric clamp: the most negative code never reaches storage.
  function automatic logic [Q-1:0] sat(
    input logic [QI-1:0] x
  );
    logic signed [QI-1:0] s;
    s = $signed(x);
    if (s > SMAX)
      return SMAX[Q-1:0];
    else if (s < SMIN)
      return SMIN[Q-1:0];
    else
      return x[Q-1:0];
  endfunction

  always_comb begin
    wbuf_nxt = wbuf;
    for (int k = 0; k < K; k++) begin
      wbuf_nxt[(int'(bcnt) * K + k) * Q +: Q] =
        sat(llr_in[k*QI +: QI]);
    end
  end

  assign llr_ready     = (state == LOAD);
  assign channel_ready = (state == EMIT);
  assign channel       = (state == DECODE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= LOAD;
      bcnt          <= '0;
      wcnt          <= '0;
      wbuf          <= '0;
      W_channel     <= '0;
      channel_count <= '0;
    end else if (frame_abort) begin
      state <= LOAD;
      bcnt  <= '0;
      wcnt  <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (llr_valid) begin
            wbuf <= wbuf_nxt;
            if (bcnt == BLAST) begin
              bcnt          <= '0;
              W_channel     <= wbuf_nxt;
              channel_count <= wcnt;
              state         <= EMIT;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        EMIT: begin
          if (wcnt == WLAST) begin
            wcnt  <= '0;
            state <= DECODE;
          end else begin
            wcnt  <= wcnt + 1'b1;
            state <= LOAD;
          end
        end
        DECODE: begin
          if (decode_done)
            state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_loader.sv
// tb_channel_loader: directed scenarios for channel_loader with
// hand-computed and model-derived expected words.
module tb_channel_loader;

  localparam int N = 1024;
  localparam int P = 128;
  localparam int Q = 6;
  localparam int K = 8;
  localparam int QI = 8;
  localparam int WORDS = N / P;
  localparam int BEATS = P / K;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [K*QI-1:0] llr_in = '0;
  logic            llr_valid = 1'b0;
  logic            llr_ready;
  logic            decode_done = 1'b0;
  logic            frame_abort = 1'b0;
  logic [P*Q-1:0]  W_channel;
  logic [5:0]      channel_count;
  logic            channel_ready;
  logic            channel;

  channel_loader #(
    .N(N), .P(P), .Q(Q), .K(K), .QI(QI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .llr_in(llr_in),
    .llr_valid(llr_valid),
    .llr_ready(llr_ready),
    .decode_done(decode_done),
    .frame_abort(frame_abort),
    .W_channel(W_channel),
    .channel_count(channel_count),
    .channel_ready(channel_ready),
    .channel(channel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int viol = 0;
  int rise_cyc = -1;
  logic chan_prev = 1'b0;

  typedef struct {
    int             cnt;
    logic [P*Q-1:0] w;
    int             c;
  } rec_t;

  rec_t q[$];
  rec_t mrec;

  int sat_tbl[8] = '{127, -128, 31, -31, -32, 32, 0, -1};
  int exp_sat[8] = '{31, -31, 31, -31, -31, 31, 0, -1};

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (channel_ready) begin
      mrec.cnt = int'(channel_count);
      mrec.w = W_channel;
      mrec.c = cyc;
      q.push_back(mrec);
    end
    if (llr_ready && (channel_ready || channel))
      viol++;
    if (channel && !chan_prev)
      rise_cyc = cyc;
    chan_prev = channel;
  end

  function automatic int val(input int fid, input int j,
                             input int k);
    if (fid == 0)
      return ((j * K + k) % 32) - 16;
    if (fid == 2 && j == 0)
      return sat_tbl[k];
    return (((j * K + k) * 37 + fid * 11) % 256) - 128;
  endfunction

  function automatic logic [Q-1:0] satq(input int v);
    if (v > 31) return 6'd31;
    if (v < -31) return 6'(-31);
    return 6'(v);
  endfunction

  function automatic logic [P*Q-1:0] exp_word(input int fid,
                                              input int w);
    logic [P*Q-1:0] r;
    r = '0;
    for (int s = 0; s < P; s++)
      r[s*Q +: Q] = satq(val(fid, w * BEATS + s / K, s % K));
    return r;
  endfunction

  task automatic send_beats(input int fid, input int first,
                            input int nb, input bit gaps,
                            output int c0);
    int j;
    int budget;
    bit acc;
    j = first;
    budget = 0;
    c0 = cyc;
    while (j < first + nb && budget < 4000) begin
      llr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int k = 0; k < K; k++)
        llr_in[k*QI +: QI] = QI'(val(fid, j, k));
      acc = llr_valid && llr_ready;
      @(posedge clk);
      #1;
      budget++;
      if (acc) j++;
    end
    llr_valid = 1'b0;
    checks++;
    if (j != first + nb) begin
      errors++;
      $display("FAIL send_beats timeout: sent %0d need %0d",
               j - first, nb);
    end
  endtask

  task automatic end_decode();
    decode_done = 1'b1;
    @(posedge clk);
    #1;
    decode_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (llr_ready !== 1'b1 || channel_ready !== 1'b0 ||
        channel !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: rdy=%b strobe=%b chan=%b want 1 0 0",
               llr_ready, channel_ready, channel);
    end
    checks++;
    if (channel_count !== 6'd0 || W_channel !== '0) begin
      errors++;
      $display("FAIL reset_data: count=%0d word_nonzero=%b want 0 0",
               channel_count, |W_channel);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_frame();
    int c0;
    q.delete();
    rise_cyc = -1;
    send_beats(0, 0, WORDS * BEATS, 1'b0, c0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != WORDS) begin
      errors++;
      $display("FAIL full_nwords: got %0d want %0d", q.size(), WORDS);
    end
    for (int i = 0; i < q.size(); i++) begin
      checks++;
      if (q[i].cnt != i || q[i].c - c0 + 1 != 17 * (i + 1)) begin
        errors++;
        $display("FAIL full_strobe %0d: count=%0d cycle=%0d want %0d %0d",
                 i, q[i].cnt, q[i].c - c0 + 1, i, 17 * (i + 1));
      end
      checks++;
      if (q[i].w !== exp_word(0, i)) begin
        errors++;
        $display("FAIL full_word %0d: got %h want %h",
                 i, q[i].w, exp_word(0, i));
      end
    end
    if (q.size() > 0) begin
      checks++;
      if (q[0].w[5:0] !== 6'b110000 ||
          q[0].w[31*Q +: Q] !== 6'b001111) begin
        errors++;
        $display("FAIL full_slots: s0=%b s31=%b want 110000 001111",
                 q[0].w[5:0], q[0].w[31*Q +: Q]);
      end
    end
    checks++;
    if (rise_cyc - c0 + 1 != 137 || channel !== 1'b1) begin
      errors++;
      $display("FAIL full_channel: rise=%0d chan=%b want 137 1",
               rise_cyc - c0 + 1, channel);
    end
  endtask

  task automatic test_decode_hold();
    int c0;
    int rdy_hi;
    q.delete();
    rdy_hi = 0;
    llr_valid = 1'b1;
    llr_in = 64'h0123_4567_89ab_cdef;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (llr_ready) rdy_hi++;
    end
    checks++;
    if (rdy_hi != 0 || q.size() != 0 || channel !== 1'b1) begin
      errors++;
      $display("FAIL hold_decode: rdy_cycles=%0d strobes=%0d chan=%b want 0 0 1",
               rdy_hi, q.size(), channel);
    end
    llr_valid = 1'b0;
    end_decode();
    checks++;
    if (channel !== 1'b0 || llr_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: chan=%b rdy=%b want 0 1",
               channel, llr_ready);
    end
    send_beats(1, 0, WORDS * BEATS, 1'b0, c0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != WORDS) begin
      errors++;
      $display("FAIL hold_nwords: got %0d want %0d", q.size(), WORDS);
    end
    for (int i = 0; i < q.size(); i++) begin
      checks++;
      if (q[i].cnt != i || q[i].w !== exp_word(1, i)) begin
        errors++;
        $display("FAIL hold_word %0d: count=%0d got %h want %h",
                 i, q[i].cnt, q[i].w, exp_word(1, i));
      end
    end
    end_decode();
  endtask

  task automatic test_saturation();
    int c0;
    int neg32;
    q.delete();
    send_beats(2, 0, WORDS * BEATS, 1'b0, c0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != WORDS) begin
      errors++;
      $display("FAIL sat_nwords: got %0d want %0d", q.size(), WORDS);
    end
    if (q.size() > 0) begin
      for (int s = 0; s < K; s++) begin
        checks++;
        if (q[0].w[s*Q +: Q] !== 6'(exp_sat[s])) begin
          errors++;
          $display("FAIL sat_slot %0d: got %0d want %0d", s,
                   $signed(q[0].w[s*Q +: Q]), exp_sat[s]);
        end
      end
    end
    neg32 = 0;
    for (int i = 0; i < q.size(); i++) begin
      for (int s = 0; s < P; s++)
        if (q[i].w[s*Q +: Q] == 6'b100000) neg32++;
      checks++;
      if (q[i].w !== exp_word(2, i)) begin
        errors++;
        $display("FAIL sat_word %0d: got %h want %h",
                 i, q[i].w, exp_word(2, i));
      end
    end
    checks++;
    if (neg32 != 0) begin
      errors++;
      $display("FAIL sat_neg32: got %0d slots want 0", neg32);
    end
    end_decode();
  endtask

  task automatic test_gaps();
    int c0;
    q.delete();
    viol = 0;
    send_beats(0, 0, WORDS * BEATS, 1'b1, c0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != WORDS) begin
      errors++;
      $display("FAIL gap_nwords: got %0d want %0d", q.size(), WORDS);
    end
    for (int i = 0; i < q.size(); i++) begin
      checks++;
      if (q[i].cnt != i || q[i].w !== exp_word(0, i)) begin
        errors++;
        $display("FAIL gap_word %0d: count=%0d got %h want %h",
                 i, q[i].cnt, q[i].w, exp_word(0, i));
      end
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL gap_ready: ready-in-emit/decode=%0d want 0", viol);
    end
    end_decode();
  endtask

  task automatic test_abort();
    int c0;
    q.delete();
    send_beats(3, 0, 3 * BEATS + 5, 1'b0, c0);
    frame_abort = 1'b1;
    llr_valid = 1'b1;
    llr_in = 64'h7f7f_7f7f_7f7f_7f7f;
    @(posedge clk);
    #1;
    frame_abort = 1'b0;
    llr_valid = 1'b0;
    checks++;
    if (llr_ready !== 1'b1 || channel !== 1'b0 || q.size() != 3) begin
      errors++;
      $display("FAIL abort_state: rdy=%b chan=%b words=%0d want 1 0 3",
               llr_ready, channel, q.size());
    end
    q.delete();
    send_beats(4, 0, WORDS * BEATS, 1'b0, c0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != WORDS) begin
      errors++;
      $display("FAIL abort_nwords: got %0d want %0d", q.size(), WORDS);
    end
    for (int i = 0; i < q.size(); i++) begin
      checks++;
      if (q[i].cnt != i || q[i].w !== exp_word(4, i)) begin
        errors++;
        $display("FAIL abort_word %0d: count=%0d got %h want %h",
                 i, q[i].cnt, q[i].w, exp_word(4, i));
      end
    end
    end_decode();
  endtask

  task automatic test_ignored_ctrl();
    int c0;
    q.delete();
    decode_done = 1'b1;
    @(posedge clk);
    #1;
    decode_done = 1'b0;
    frame_abort = 1'b1;
    @(posedge clk);
    #1;
    frame_abort = 1'b0;
    checks++;
    if (llr_ready !== 1'b1 || channel !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL idle_ctrl: rdy=%b chan=%b strobes=%0d want 1 0 0",
               llr_ready, channel, q.size());
    end
    send_beats(5, 0, 5, 1'b0, c0);
    end_decode();
    send_beats(5, 5, WORDS * BEATS - 5, 1'b0, c0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != WORDS || channel !== 1'b1) begin
      errors++;
      $display("FAIL done_in_load: words=%0d chan=%b want %0d 1",
               q.size(), channel, WORDS);
    end
    for (int i = 0; i < q.size(); i++) begin
      checks++;
      if (q[i].cnt != i || q[i].w !== exp_word(5, i)) begin
        errors++;
        $display("FAIL done_word %0d: count=%0d got %h want %h",
                 i, q[i].cnt, q[i].w, exp_word(5, i));
      end
    end
    end_decode();
  endtask

  task automatic test_async_reset();
    int c0;
    send_beats(6, 0, BEATS, 1'b0, c0);
    checks++;
    if (channel_ready !== 1'b1 || channel_count !== 6'd0) begin
      errors++;
      $display("FAIL arst_emit_pre: strobe=%b count=%0d want 1 0",
               channel_ready, channel_count);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (channel_ready !== 1'b0 || llr_ready !== 1'b1 ||
        channel !== 1'b0 || W_channel !== '0) begin
      errors++;
      $display("FAIL arst_emit: strobe=%b rdy=%b chan=%b word_nz=%b want 0 1 0 0",
               channel_ready, llr_ready, channel, |W_channel);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_beats(6, 0, WORDS * BEATS, 1'b0, c0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (channel !== 1'b1) begin
      errors++;
      $display("FAIL arst_decode_pre: chan=%b want 1", channel);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (channel !== 1'b0 || llr_ready !== 1'b1 ||
        channel_count !== 6'd0 || W_channel !== '0) begin
      errors++;
      $display("FAIL arst_decode: chan=%b rdy=%b count=%0d word_nz=%b want 0 1 0 0",
               channel, llr_ready, channel_count, |W_channel);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    send_beats(7, 0, WORDS * BEATS, 1'b0, c0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != WORDS) begin
      errors++;
      $display("FAIL arst_nwords: got %0d want %0d", q.size(), WORDS);
    end
    for (int i = 0; i < q.size(); i++) begin
      checks++;
      if (q[i].cnt != i || q[i].w !== exp_word(7, i)) begin
        errors++;
        $display("FAIL arst_word %0d: count=%0d got %h want %h",
                 i, q[i].cnt, q[i].w, exp_word(7, i));
      end
    end
    end_decode();
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_decode_hold();
    test_saturation();
    test_gaps();
    test_abort();
    test_ignored_ctrl();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
